alu_arbiter: RTL and testbench

//  Shares the single combinational ALU between two requesters (port 0: main

---
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Operands are latched, the ALU is evaluated once per transaction and the result is held until consumed.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 3,
  parameter bit RR_INIT = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [OPW-1:0]   req0_op_i,
  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic [WIDTH-1:0] rsp0_result_o,
  output logic             rsp0_ov_o,
  output logic             rsp0_zero_o,
  output logic             rsp0_err_o,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [OPW-1:0]   req1_op_i,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [WIDTH-1:0] rsp1_result_o,
  output logic             rsp1_ov_o,
  output logic             rsp1_zero_o,
  output logic             rsp1_err_o,
  output logic [WIDTH-1:0] alu_in1_o,
  output logic [WIDTH-1:0] alu_in2_o,
  output logic [OPW-1:0]   alu_op_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic             alu_ov_i
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(6);
  localparam logic [OPW-1:0] OP_R3  = OPW'(3);
  localparam logic [OPW-1:0] OP_R4  = OPW'(4);
  localparam logic [OPW-1:0] OP_R5  = OPW'(5);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e           state_q;
  logic             last_grant_q;
  logic             owner_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] result_q;
  logic             ov_q;
  logic             zero_q;
  logic             err_q;
  logic [1:0]       rsp_valid_q;

  logic             grant_valid_d;
  logic             grant_d;
  logic             accept_d;
  logic [WIDTH-1:0] sel_a_d;
  logic [WIDTH-1:0] sel_b_d;
  logic [OPW-1:0]   sel_op_d;
  logic             is_addsub_d;
  logic             is_unsup_d;
  logic             owner_ready_d;

  // On a tie the port that did not win last time is served.
  always_comb begin
    grant_valid_d = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      grant_d = ~last_grant_q;
    end else begin
      grant_d = req1_valid_i;
    end
    sel_a_d  = grant_d ? req1_a_i  : req0_a_i;
    sel_b_d  = grant_d ? req1_b_i  : req0_b_i;
    sel_op_d = grant_d ? req1_op_i : req0_op_i;
  end

  assign accept_d      = (state_q == S_IDLE) && grant_valid_d && !reset_i;
  assign req0_ready_o  = accept_d && !grant_d;
  assign req1_ready_o  = accept_d && grant_d;

  assign is_addsub_d   = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign is_unsup_d    = (op_q == OP_R3) || (op_q == OP_R4) || (op_q == OP_R5);
  assign owner_ready_d = owner_q ? rsp1_ready_i : rsp0_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= RR_INIT;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      ov_q         <= 1'b0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_valid_d) begin
            a_q          <= sel_a_d;
            b_q          <= sel_b_d;
            op_q         <= sel_op_d;
            owner_q      <= grant_d;
            last_grant_q <= grant_d;
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q    <= alu_out_i;
          ov_q        <= is_addsub_d & alu_ov_i;
          zero_q      <= (alu_out_i == '0);
          err_q       <= is_unsup_d;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (owner_ready_d) begin
            rsp_valid_q <= 2'b00;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // The ALU sees only latched operands, so its inputs never follow the live request buses.
  assign alu_in1_o = a_q;
  assign alu_in2_o = b_q;
  assign alu_op_o  = op_q;

  // Both ports observe the single response buffer; only the owner's valid is raised.
  assign rsp0_valid_o  = rsp_valid_q[0];
  assign rsp1_valid_o  = rsp_valid_q[1];
  assign rsp0_result_o = result_q;
  assign rsp1_result_o = result_q;
  assign rsp0_ov_o     = ov_q;
  assign rsp1_ov_o     = ov_q;
  assign rsp0_zero_o   = zero_q;
  assign rsp1_zero_o   = zero_q;
  assign rsp0_err_o    = err_q;
  assign rsp1_err_o    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// checked against an arithmetic reference model; the ALU itself is modelled here.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd6, OP_SLT = 3'd7;

  logic clk = 1'b0;
  logic reset;
  logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready, rsp_ov, rsp_zero, rsp_err;
  logic [W-1:0] req_a [2];
  logic [W-1:0] req_b [2];
  logic [2:0]   req_op [2];
  logic [W-1:0] rsp_result [2];
  logic [W-1:0] alu_in1, alu_in2, alu_out, alu_sum, alu_diff;
  logic [2:0]   alu_op;
  logic         alu_ov;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .OPW(3), .RR_INIT(1'b1)) dut (
    .clk_i(clk), .reset_i(reset),
    .req0_valid_i(req_valid[0]), .req0_ready_o(req_ready[0]), .req0_a_i(req_a[0]),
    .req0_b_i(req_b[0]), .req0_op_i(req_op[0]),
    .rsp0_valid_o(rsp_valid[0]), .rsp0_ready_i(rsp_ready[0]), .rsp0_result_o(rsp_result[0]),
    .rsp0_ov_o(rsp_ov[0]), .rsp0_zero_o(rsp_zero[0]), .rsp0_err_o(rsp_err[0]),
    .req1_valid_i(req_valid[1]), .req1_ready_o(req_ready[1]), .req1_a_i(req_a[1]),
    .req1_b_i(req_b[1]), .req1_op_i(req_op[1]),
    .rsp1_valid_o(rsp_valid[1]), .rsp1_ready_i(rsp_ready[1]), .rsp1_result_o(rsp_result[1]),
    .rsp1_ov_o(rsp_ov[1]), .rsp1_zero_o(rsp_zero[1]), .rsp1_err_o(rsp_err[1]),
    .alu_in1_o(alu_in1), .alu_in2_o(alu_in2), .alu_op_o(alu_op),
    .alu_out_i(alu_out), .alu_ov_i(alu_ov)
  );

  // External ALU: raises ov for every non-add/sub op so the arbiter must mask it.
  always_comb begin
    alu_sum  = alu_in1 + alu_in2;
    alu_diff = alu_in1 - alu_in2;
    alu_out  = '0;
    alu_ov   = 1'b1;
    case (alu_op)
      OP_AND: alu_out = alu_in1 & alu_in2;
      OP_OR:  alu_out = alu_in1 | alu_in2;
      OP_ADD: begin
        alu_out = alu_sum;
        alu_ov  = (alu_in1[W-1] == alu_in2[W-1]) && (alu_sum[W-1] != alu_in1[W-1]);
      end
      OP_SUB: begin
        alu_out = alu_diff;
        alu_ov  = (alu_in1[W-1] != alu_in2[W-1]) && (alu_diff[W-1] != alu_in1[W-1]);
      end
      OP_SLT: alu_out = {{(W-1){1'b0}}, ($signed(alu_in1) < $signed(alu_in2))};
      default: ;
    endcase
  end

  function automatic logic [W-1:0] model_result(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  function automatic logic model_ov(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_ADD) s = sa + sb;
    else if (op == OP_SUB) s = sa - sb;
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic logic model_err(input logic [2:0] op);
    return (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
  endfunction

  // Drives one request on port p, waits for its response, holds rsp_ready low for
  // 'hold' cycles, then consumes it. Returns what was observed.
  task automatic run_txn(input int p, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input int hold, output logic [W-1:0] r, output logic ov, output logic zero,
                         output logic err, output int lat, output logic ready_after,
                         output logic stable, output logic released);
    int n;
    lat = -1; stable = 1'b1; released = 1'b0; ready_after = 1'b1;
    r = '0; ov = 1'b0; zero = 1'b0; err = 1'b0;
    @(negedge clk);
    req_valid[p] = 1'b1; req_a[p] = a; req_b[p] = b; req_op[p] = op;
    #1;
    n = 0;
    while (!req_ready[p] && n < 50) begin @(negedge clk); #1; n++; end
    if (!req_ready[p]) begin req_valid[p] = 1'b0; return; end
    @(negedge clk);
    req_valid[p] = 1'b0;
    #1;
    ready_after = req_ready[p];
    n = 1;
    while (!rsp_valid[p] && n < 20) begin @(negedge clk); #1; n++; end
    if (!rsp_valid[p]) return;
    lat = n;
    r = rsp_result[p]; ov = rsp_ov[p]; zero = rsp_zero[p]; err = rsp_err[p];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      if (!rsp_valid[p] || rsp_result[p] !== r || rsp_ov[p] !== ov || rsp_zero[p] !== zero || rsp_err[p] !== err)
        stable = 1'b0;
    end
    rsp_ready[p] = 1'b1;
    @(negedge clk);
    rsp_ready[p] = 1'b0;
    #1;
    released = !rsp_valid[p];
    $display("txn port=%0d op=%0d a=%h b=%h -> result=%h ov=%0b zero=%0b err=%0b lat=%0d",
             p, op, a, b, r, ov, zero, err, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11;
    @(negedge clk); #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    n_checks++; if (rsp_result[0] !== '0 || rsp_ov !== 2'b00 || rsp_zero !== 2'b00 || rsp_err !== 2'b00) begin
      n_fail++; $display("FAIL reset_rsp_regs result=%h ov=%b zero=%b err=%b exp all 0", rsp_result[0], rsp_ov, rsp_zero, rsp_err); end
    n_checks++; if (alu_in1 !== '0 || alu_in2 !== '0 || alu_op !== 3'd0) begin
      n_fail++; $display("FAIL reset_alu in1=%h in2=%h op=%0d exp 0", alu_in1, alu_in2, alu_op); end
    req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] r; logic ov, zero, err, ra, st, rel; int lat;
    run_txn(0, 32'd5, 32'd7, OP_ADD, 0, r, ov, zero, err, lat, ra, st, rel);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL t1_latency got=%0d exp=2", lat); end
    n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL t1_ready_pulse got=%b exp=0 in cycle after accept", ra); end
    n_checks++; if (r !== 32'd12) begin n_fail++; $display("FAIL t1_result got=%h exp=0000000c", r); end
    n_checks++; if ({ov, zero, err} !== 3'b000) begin n_fail++; $display("FAIL t1_flags got=%b exp=000", {ov, zero, err}); end
    n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL t1_release got=%b exp=1", rel); end
  endtask

  task automatic test_tie();
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    @(negedge clk);
    req_valid = 2'b11;
    req_a[0] = 32'd3; req_b[0] = 32'd3; req_op[0] = OP_SUB;
    req_a[1] = 32'd0; req_b[1] = 32'd0; req_op[1] = OP_OR;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL t2_first_grant got=%b exp=01", req_ready); end
    @(negedge clk); req_valid[0] = 1'b0; #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL t2_busy_ready got=%b exp=00", req_ready); end
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 2'b01 || rsp_result[0] !== '0 || rsp_zero[0] !== 1'b1) begin
      n_fail++; $display("FAIL t2_rsp0 valid=%b result=%h zero=%b exp valid=01 result=0 zero=1", rsp_valid, rsp_result[0], rsp_zero[0]); end
    rsp_ready[0] = 1'b1;
    @(negedge clk); rsp_ready[0] = 1'b0; #1;
    n_checks++; if (req_ready !== 2'b10 || rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL t2_second_grant ready=%b rsp_valid=%b exp ready=10 rsp_valid=00", req_ready, rsp_valid); end
    @(negedge clk); req_valid[1] = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (rsp_valid !== 2'b10 || rsp_result[1] !== '0 || rsp_zero[1] !== 1'b1) begin
      n_fail++; $display("FAIL t2_rsp1 valid=%b result=%h zero=%b exp valid=10 result=0 zero=1", rsp_valid, rsp_result[1], rsp_zero[1]); end
    rsp_ready[1] = 1'b1;
    @(negedge clk); rsp_ready[1] = 1'b0;
  endtask

  task automatic test_overflow();
    logic [W-1:0] r; logic ov, zero, err, ra, st, rel; int lat;
    run_txn(0, 32'h7FFF_FFFF, 32'd1, OP_ADD, 1, r, ov, zero, err, lat, ra, st, rel);
    n_checks++; if (r !== 32'h8000_0000 || ov !== 1'b1 || zero !== 1'b0) begin
      n_fail++; $display("FAIL t3_add_ov result=%h ov=%b zero=%b exp 80000000/1/0", r, ov, zero); end
    run_txn(0, 32'h0000_00F0, 32'h0000_000F, OP_AND, 0, r, ov, zero, err, lat, ra, st, rel);
    n_checks++; if (r !== '0 || ov !== 1'b0 || zero !== 1'b1) begin
      n_fail++; $display("FAIL t3_and_masked result=%h ov=%b zero=%b exp 0/0/1", r, ov, zero); end
  endtask

  task automatic test_slt_err();
    logic [W-1:0] r; logic ov, zero, err, ra, st, rel; int lat;
    run_txn(1, 32'd2, 32'd9, OP_SLT, 0, r, ov, zero, err, lat, ra, st, rel);
    n_checks++; if (r !== 32'd1 || zero !== 1'b0 || err !== 1'b0 || ov !== 1'b0) begin
      n_fail++; $display("FAIL t4_slt result=%h zero=%b err=%b ov=%b exp 1/0/0/0", r, zero, err, ov); end
    run_txn(1, 32'd2, 32'd9, 3'd4, 0, r, ov, zero, err, lat, ra, st, rel);
    n_checks++; if (r !== '0 || err !== 1'b1 || ov !== 1'b0) begin
      n_fail++; $display("FAIL t4_unsupported result=%h err=%b ov=%b exp 0/1/0", r, err, ov); end
  endtask

  task automatic test_backpressure();
    logic held;
    @(negedge clk);
    req_valid[0] = 1'b1; req_a[0] = 32'd3; req_b[0] = 32'd4; req_op[0] = OP_ADD;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL t5_accept0 got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_a[1] = 32'd100; req_b[1] = 32'd1; req_op[1] = OP_SUB;
    @(negedge clk); #1;
    n_checks++; if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 32'd7) begin
      n_fail++; $display("FAIL t5_rsp0 valid=%b result=%h exp 1/00000007", rsp_valid[0], rsp_result[0]); end
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (rsp_valid[0] !== 1'b1 || rsp_result[0] !== 32'd7 || req_ready[1] !== 1'b0) held = 1'b0;
    end
    n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL t5_hold got=%b exp=1 (rsp0 stable, req1_ready low)", held); end
    rsp_ready[0] = 1'b1;
    @(negedge clk); rsp_ready[0] = 1'b0; #1;
    n_checks++; if (rsp_valid[0] !== 1'b0 || req_ready[1] !== 1'b1) begin
      n_fail++; $display("FAIL t5_release rsp0_valid=%b req1_ready=%b exp 0/1", rsp_valid[0], req_ready[1]); end
    @(negedge clk); req_valid[1] = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (rsp_valid[1] !== 1'b1 || rsp_result[1] !== 32'd99) begin
      n_fail++; $display("FAIL t5_rsp1 valid=%b result=%h exp 1/00000063", rsp_valid[1], rsp_result[1]); end
    rsp_ready[1] = 1'b1;
    @(negedge clk); rsp_ready[1] = 1'b0;
  endtask

  task automatic test_reset_exec();
    logic [W-1:0] r; logic ov, zero, err, ra, st, rel, quiet; int lat;
    @(negedge clk);
    req_valid[1] = 1'b1; req_a[1] = 32'd55; req_b[1] = 32'd5; req_op[1] = OP_SUB;
    #1;
    n_checks++; if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL t6_accept got=%b exp=1", req_ready[1]); end
    @(negedge clk); req_valid[1] = 1'b0; #1;
    n_checks++; if (alu_in1 !== 32'd55 || alu_op !== OP_SUB) begin
      n_fail++; $display("FAIL t6_exec_alu in1=%h op=%0d exp 00000037/6", alu_in1, alu_op); end
    #1 reset = 1'b1; #1;
    n_checks++; if (alu_in1 !== '0 || alu_op !== 3'd0 || rsp_valid !== 2'b00 || req_ready !== 2'b00 || rsp_result[1] !== '0) begin
      n_fail++; $display("FAIL t6_async_reset in1=%h op=%0d rsp_valid=%b ready=%b result=%h exp all 0",
                         alu_in1, alu_op, rsp_valid, req_ready, rsp_result[1]); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); #1; if (rsp_valid !== 2'b00) quiet = 1'b0; end
    n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL t6_no_rsp got=%b exp=1", quiet); end
    run_txn(1, 32'd10, 32'd4, OP_SUB, 0, r, ov, zero, err, lat, ra, st, rel);
    n_checks++; if (r !== 32'd6 || lat !== 2) begin n_fail++; $display("FAIL t6_after_reset result=%h lat=%0d exp 00000006/2", r, lat); end
  endtask

  task automatic test_fairness();
    int n;
    logic g;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    rsp_ready = 2'b11;
    @(negedge clk);
    req_valid = 2'b11;
    for (int p = 0; p < 2; p++) begin req_a[p] = 32'(p); req_b[p] = 32'd1; req_op[p] = OP_ADD; end
    #1;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (req_ready === 2'b00 && n < 10) begin @(negedge clk); #1; n++; end
      n_checks++;
      if (req_ready !== 2'b01 && req_ready !== 2'b10) begin
        n_fail++; $display("FAIL fair_grant_%0d ready=%b exp one-hot", k, req_ready); break; end
      g = req_ready[1];
      n_checks++; if (g !== 1'(k % 2)) begin n_fail++; $display("FAIL fair_order_%0d got=%0d exp=%0d", k, g, k % 2); end
      $display("txn fairness grant %0d -> port %0d", k, g);
      @(negedge clk);
      req_a[g] = req_a[g] + 32'd2;
      #1;
    end
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_random();
    logic [W-1:0] r, a, b, er; logic ov, zero, err, ra, st, rel; int lat, p, hold;
    logic [2:0] op;
    logic [2:0] ops [6] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, 3'd3};
    for (int i = 0; i < 40; i++) begin
      p = int'($urandom_range(0, 1));
      op = ops[$urandom_range(0, 5)];
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h7FFF_FFFF;
        1: b = 32'h8000_0000;
        2: b = a;
        3: a = 32'hFFFF_FFFF;
        default: ;
      endcase
      hold = int'($urandom_range(0, 2));
      run_txn(p, a, b, op, hold, r, ov, zero, err, lat, ra, st, rel);
      er = model_result(op, a, b);
      n_checks++; if (r !== er) begin n_fail++; $display("FAIL rnd%0d_result got=%h exp=%h", i, r, er); end
      n_checks++; if ({ov, zero, err} !== {model_ov(op, a, b), (er == '0), model_err(op)}) begin
        n_fail++; $display("FAIL rnd%0d_flags got=%b exp=%b", i, {ov, zero, err}, {model_ov(op, a, b), (er == '0), model_err(op)}); end
      n_checks++; if (lat !== 2 || st !== 1'b1 || rel !== 1'b1 || ra !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_handshake lat=%0d stable=%b released=%b ready_after=%b exp 2/1/1/0", i, lat, st, rel, ra); end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    for (int p = 0; p < 2; p++) begin req_a[p] = '0; req_b[p] = '0; req_op[p] = '0; end
    test_reset();
    test_basic();
    test_tie();
    test_overflow();
    test_slt_err();
    test_backpressure();
    test_reset_exec();
    test_fairness();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
